// File: rtl/splitting_mul.sv
// Two-stage operand splitter for a single-precision multiplier: stage 1 captures
// the raw operands, stage 2 holds sign, exponents, mantissas and the special-case class.
module splitting_mul (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        out_ready,
    output logic        out_valid,
    output logic        S,
    output logic [7:0]  Ea,
    output logic [7:0]  Eb,
    output logic [23:0] Ma,
    output logic [23:0] Mb,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_nan,
    output logic        denorm
);

    logic        s1_valid_q;
    logic [31:0] a_q;
    logic [31:0] b_q;

    logic        s2_valid_q;
    logic        s_q;
    logic [7:0]  ea_q;
    logic [7:0]  eb_q;
    logic [23:0] ma_q;
    logic [23:0] mb_q;
    logic        zero_q;
    logic        inf_q;
    logic        nan_q;
    logic        denorm_q;

    logic        s1_advance;

    logic [31:0] op    [2];
    logic [7:0]  exp_d [2];
    logic [23:0] man_d [2];
    logic [1:0]  op_zero;
    logic [1:0]  op_sub;
    logic [1:0]  op_inf;
    logic [1:0]  op_nan;

    logic        s_d;
    logic        nan_d;
    logic        inf_d;
    logic        zero_d;
    logic        denorm_d;

    assign s1_advance = !s2_valid_q || out_ready;
    // Both handshakes are forced low while reset is held so nothing transfers in that cycle.
    assign in_ready   = !rst && (!s1_valid_q || s1_advance);
    assign out_valid  = !rst && s2_valid_q;

    assign op[0] = a_q;
    assign op[1] = b_q;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dec
            logic [7:0]  e;
            logic [22:0] f;
            logic        normal;

            assign e           = op[gi][30:23];
            assign f           = op[gi][22:0];
            assign normal      = (e != 8'h00) && (e != 8'hFF);
            // Subnormals are flushed, so they fall into the zero class as well.
            assign op_zero[gi] = (e == 8'h00);
            assign op_sub[gi]  = (e == 8'h00) && (f != 23'd0);
            assign op_inf[gi]  = (e == 8'hFF) && (f == 23'd0);
            assign op_nan[gi]  = (e == 8'hFF) && (f != 23'd0);
            assign exp_d[gi]   = e;
            assign man_d[gi]   = op_sub[gi] ? 24'd0 : {normal, f};
        end
    endgenerate

    assign s_d      = a_q[31] ^ b_q[31];
    assign nan_d    = (|op_nan) || (op_inf[0] && op_zero[1]) || (op_inf[1] && op_zero[0]);
    assign inf_d    = (|op_inf) && !nan_d;
    assign zero_d   = (|op_zero) && !nan_d;
    assign denorm_d = |op_sub;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            s2_valid_q <= 1'b0;
            s_q        <= 1'b0;
            ea_q       <= '0;
            eb_q       <= '0;
            ma_q       <= '0;
            mb_q       <= '0;
            zero_q     <= 1'b0;
            inf_q      <= 1'b0;
            nan_q      <= 1'b0;
            denorm_q   <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    a_q <= A;
                    b_q <= B;
                end
            end
            if (s1_advance) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s_q      <= s_d;
                    ea_q     <= exp_d[0];
                    eb_q     <= exp_d[1];
                    ma_q     <= man_d[0];
                    mb_q     <= man_d[1];
                    zero_q   <= zero_d;
                    inf_q    <= inf_d;
                    nan_q    <= nan_d;
                    denorm_q <= denorm_d;
                end
            end
        end
    end

    assign S       = s_q;
    assign Ea      = ea_q;
    assign Eb      = eb_q;
    assign Ma      = ma_q;
    assign Mb      = mb_q;
    assign is_zero = zero_q;
    assign is_inf  = inf_q;
    assign is_nan  = nan_q;
    assign denorm  = denorm_q;

endmodule

// File: tb/tb_splitting_mul.sv
// Bench for splitting_mul: directed decode vectors plus randomized traffic checked
// against an arithmetic reference decoder and an in-order expectation queue.
module tb_splitting_mul;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic        in_valid;
    logic        in_ready;
    logic        out_ready;
    logic        out_valid;
    logic        S;
    logic [7:0]  Ea;
    logic [7:0]  Eb;
    logic [23:0] Ma;
    logic [23:0] Mb;
    logic        is_zero;
    logic        is_inf;
    logic        is_nan;
    logic        denorm;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    splitting_mul dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .S         (S),
        .Ea        (Ea),
        .Eb        (Eb),
        .Ma        (Ma),
        .Mb        (Mb),
        .is_zero   (is_zero),
        .is_inf    (is_inf),
        .is_nan    (is_nan),
        .denorm    (denorm)
    );

    // Packed view: {S, Ea, Ma, Eb, Mb, is_zero, is_inf, is_nan, denorm}
    function automatic logic [68:0] dut_fields();
        return {S, Ea, Ma, Eb, Mb, is_zero, is_inf, is_nan, denorm};
    endfunction

    function automatic logic [68:0] ref_decode(input logic [31:0] a, input logic [31:0] b);
        logic [7:0]  ex [2];
        logic [23:0] mx [2];
        bit          z [2];
        bit          inf [2];
        bit          nan [2];
        bit          sub [2];
        logic [31:0] x;
        int          e;
        int          f;
        bit          r_nan;
        bit          r_inf;
        bit          r_zero;
        for (int k = 0; k < 2; k++) begin
            x = (k == 0) ? a : b;
            e = int'(x[30:23]);
            f = int'(x[22:0]);
            z[k] = 0; inf[k] = 0; nan[k] = 0; sub[k] = 0;
            if (e == 0 && f == 0)  z[k] = 1;
            else if (e == 0)       begin sub[k] = 1; z[k] = 1; end
            else if (e == 255)     begin if (f == 0) inf[k] = 1; else nan[k] = 1; end
            if (sub[k]) begin
                ex[k] = 8'd0;
                mx[k] = 24'd0;
            end else begin
                ex[k] = 8'(e);
                mx[k] = (e == 0 || e == 255) ? 24'(f) : 24'(f + 8388608);
            end
        end
        r_nan  = nan[0] || nan[1] || (inf[0] && z[1]) || (inf[1] && z[0]);
        r_inf  = !r_nan && (inf[0] || inf[1]);
        r_zero = !r_nan && (z[0] || z[1]);
        return {a[31] ^ b[31], ex[0], mx[0], ex[1], mx[1], r_zero, r_inf, r_nan, sub[0] || sub[1]};
    endfunction

    // Operand generator biased towards the special classes.
    function automatic logic [31:0] rand_operand();
        logic        s;
        logic [22:0] f;
        s = 1'($urandom_range(0, 1));
        f = 23'($urandom_range(1, 23'h7FFFFF));
        case ($urandom_range(0, 5))
            0:       return {s, 8'h00, 23'd0};
            1:       return {s, 8'h00, f};
            2:       return {s, 8'hFF, 23'd0};
            3:       return {s, 8'hFF, f};
            default: return {s, 8'($urandom_range(1, 254)), f};
        endcase
    endfunction

    // One clock cycle: entered and left at a falling edge; DUT observed 1ns after driving.
    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b, input logic ordy,
                         output logic rdy, output logic vld, output logic [68:0] obs);
        in_valid  = v;
        A         = a;
        B         = b;
        out_ready = ordy;
        #1;
        rdy = in_ready;
        vld = out_valid;
        obs = dut_fields();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; A = rand_operand(); B = rand_operand(); out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (dut_fields() !== 69'd0) begin n_fail++; $display("FAIL reset_fields: got %h expected 0", dut_fields()); end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_valid: got %b expected 0", out_valid); end
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [68:0] ve [3];
        logic        rdy, vld;
        logic [68:0] obs;
        va[0] = 32'h40400000; vb[0] = 32'hC0000000;
        ve[0] = {1'b1, 8'h80, 24'hC00000, 8'h80, 24'h800000, 4'b0000};
        va[1] = 32'h7F800000; vb[1] = 32'h00000000;
        ve[1] = {1'b0, 8'hFF, 24'h000000, 8'h00, 24'h000000, 4'b0010};
        va[2] = 32'h00000001; vb[2] = 32'h3F800000;
        ve[2] = {1'b0, 8'h00, 24'h000000, 8'h7F, 24'h800000, 4'b1001};
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, va[i], vb[i], 1'b1, rdy, vld, obs);
            n_checks++;
            if (rdy !== 1'b1) begin n_fail++; $display("FAIL dir_accept[%0d]: got %b expected 1", i, rdy); end
            cycle(1'b0, 32'd0, 32'd0, 1'b1, rdy, vld, obs);
            n_checks++;
            if (vld !== 1'b0) begin n_fail++; $display("FAIL dir_latency_early[%0d]: got %b expected 0", i, vld); end
            cycle(1'b0, 32'd0, 32'd0, 1'b1, rdy, vld, obs);
            n_checks++;
            if (vld !== 1'b1) begin n_fail++; $display("FAIL dir_latency[%0d]: got %b expected 1", i, vld); end
            n_checks++;
            if (obs !== ve[i]) begin n_fail++; $display("FAIL dir_fields[%0d]: got %h expected %h", i, obs, ve[i]); end
            $display("directed A=%h B=%h -> fields=%h", va[i], vb[i], obs);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] sa [8];
        logic [31:0] sb [8];
        logic        rdy, vld;
        logic [68:0] obs;
        logic [68:0] exp_f;
        for (int i = 0; i < 8; i++) begin sa[i] = rand_operand(); sb[i] = rand_operand(); end
        for (int i = 0; i < 10; i++) begin
            if (i < 8) cycle(1'b1, sa[i], sb[i], 1'b1, rdy, vld, obs);
            else       cycle(1'b0, 32'd0, 32'd0, 1'b1, rdy, vld, obs);
            if (i < 8) begin
                n_checks++;
                if (rdy !== 1'b1) begin n_fail++; $display("FAIL stream_accept[%0d]: got %b expected 1", i, rdy); end
            end
            n_checks++;
            if (vld !== (i >= 2)) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b expected %b", i, vld, i >= 2); end
            if (i >= 2 && vld === 1'b1) begin
                exp_f = ref_decode(sa[i-2], sb[i-2]);
                n_checks++;
                if (obs !== exp_f) begin n_fail++; $display("FAIL stream_data[%0d]: got %h expected %h", i - 2, obs, exp_f); end
                $display("stream item %0d A=%h B=%h -> fields=%h", i - 2, sa[i-2], sb[i-2], obs);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] pa [4];
        logic [31:0] pb [4];
        logic [68:0] exp_q [$];
        logic [68:0] hold;
        logic [68:0] obs;
        logic [68:0] exp_f;
        logic        rdy, vld, ordy, v;
        bit          stalled = 0;
        int          sent = 0;
        int          got = 0;
        int          idx;
        for (int i = 0; i < 4; i++) begin pa[i] = rand_operand(); pb[i] = rand_operand(); end
        hold = '0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            ordy = (cyc >= 3);
            v    = (sent < 4);
            idx  = (sent < 4) ? sent : 0;
            cycle(v, pa[idx], pb[idx], ordy, rdy, vld, obs);
            if (v && rdy) begin exp_q.push_back(ref_decode(pa[idx], pb[idx])); sent++; end
            if (cyc == 2) begin
                n_checks++;
                if (rdy !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_drop: got %b expected 0", rdy); end
                n_checks++;
                if (sent !== 2) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 2", sent); end
            end
            if (stalled) begin
                n_checks++;
                if (vld !== 1'b1 || obs !== hold) begin
                    n_fail++; $display("FAIL bp_stable: got valid=%b %h expected valid=1 %h", vld, obs, hold);
                end
            end
            if (vld === 1'b1 && ordy) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL bp_spurious: got output %h expected none", obs);
                end else begin
                    exp_f = exp_q.pop_front();
                    if (obs !== exp_f) begin n_fail++; $display("FAIL bp_order[%0d]: got %h expected %h", got, obs, exp_f); end
                end
                $display("backpressure out %0d fields=%h", got, obs);
                got++;
            end
            stalled = (vld === 1'b1) && !ordy;
            hold    = obs;
        end
        n_checks++;
        if (got !== 4) begin n_fail++; $display("FAIL bp_count: got %0d expected 4", got); end
    endtask

    task automatic test_random();
        logic [68:0] exp_q [$];
        logic [68:0] hold;
        logic [68:0] obs;
        logic [68:0] exp_f;
        logic [31:0] a, b;
        logic        rdy, vld, ordy, v;
        bit          stalled = 0;
        int          sent = 0;
        int          got = 0;
        hold = '0;
        for (int cyc = 0; cyc < 320; cyc++) begin
            v    = (cyc < 300) && ($urandom_range(0, 3) != 0);
            ordy = (cyc >= 300) || ($urandom_range(0, 3) != 0);
            a = rand_operand();
            b = rand_operand();
            cycle(v, a, b, ordy, rdy, vld, obs);
            if (v && rdy) begin exp_q.push_back(ref_decode(a, b)); sent++; end
            if (stalled) begin
                n_checks++;
                if (vld !== 1'b1 || obs !== hold) begin
                    n_fail++; $display("FAIL rand_stable[%0d]: got valid=%b %h expected valid=1 %h", cyc, vld, obs, hold);
                end
            end
            if (vld === 1'b1 && ordy) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rand_spurious[%0d]: got output %h expected none", cyc, obs);
                end else begin
                    exp_f = exp_q.pop_front();
                    if (obs !== exp_f) begin n_fail++; $display("FAIL rand_data[%0d]: got %h expected %h", got, obs, exp_f); end
                end
                got++;
            end
            stalled = (vld === 1'b1) && !ordy;
            hold    = obs;
        end
        n_checks++;
        if (got !== sent || exp_q.size() != 0) begin
            n_fail++; $display("FAIL rand_count: got %0d outputs expected %0d", got, sent);
        end
        $display("random traffic: %0d accepted, %0d emitted", sent, got);
    endtask

    task automatic test_reset_midflight();
        logic        rdy, vld;
        logic [68:0] obs;
        logic [68:0] exp_f;
        logic [31:0] a, b;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, rand_operand(), rand_operand(), 1'b1, rdy, vld, obs);
            n_checks++;
            if (rdy !== 1'b1) begin n_fail++; $display("FAIL mid_accept[%0d]: got %b expected 1", i, rdy); end
        end
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_cycle: got valid=%b ready=%b expected 0 0", out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 32'd0, 32'd0, 1'b1, rdy, vld, obs);
            n_checks++;
            if (vld !== 1'b0) begin n_fail++; $display("FAIL mid_no_stale[%0d]: got %b expected 0", i, vld); end
        end
        a = rand_operand();
        b = rand_operand();
        exp_f = ref_decode(a, b);
        cycle(1'b1, a, b, 1'b1, rdy, vld, obs);
        cycle(1'b0, 32'd0, 32'd0, 1'b1, rdy, vld, obs);
        cycle(1'b0, 32'd0, 32'd0, 1'b1, rdy, vld, obs);
        n_checks++;
        if (vld !== 1'b1 || obs !== exp_f) begin
            n_fail++; $display("FAIL mid_resume: got valid=%b %h expected valid=1 %h", vld, obs, exp_f);
        end
        $display("after mid-flight reset A=%h B=%h -> fields=%h", a, b, obs);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_streaming();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
